if_fetch_stage: RTL and testbench

Instruction-fetch stage directly upstream of the IF/ID pipeline register. Owns the PC and issues requests to a variable-latency instruction memory through a req/ready handshake. Each cycle it presents pcPlus4_IF/instr_IF to IF/ID. It honours the hazard-unit stall and later-stage branch/jump redirects, and inserts a NOP bubble whenever no valid instruction is available.

---
 rtl/if_fetch_stage.sv | 128 ++++++++++++
 tb/tb_if_fetch_stage.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, talks to a variable-latency instruction
// memory over req/ready, and feeds pcPlus4_IF/instr_IF to the IF/ID register.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pcPlus4_IF,
  output logic [31:0] instr_IF,
  output logic        instr_valid_IF
);

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_HOLD    = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] w_pc_nxt;
  logic [31:0] r_hold_buf;
  logic [31:0] w_hold_buf_nxt;
  logic [31:0] r_discard_addr;
  logic [31:0] w_discard_addr_nxt;
  logic [31:0] w_redirect_pc;
  logic [31:0] w_pc_plus4;

  assign w_redirect_pc = redirect_pc & ~32'd3;
  assign w_pc_plus4    = r_pc + 32'd4;
  assign pcPlus4_IF    = w_pc_plus4;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_FETCH;
      r_pc           <= RESET_PC;
      r_hold_buf     <= 32'd0;
      r_discard_addr <= 32'd0;
    end else begin
      r_state        <= w_state_nxt;
      r_pc           <= w_pc_nxt;
      r_hold_buf     <= w_hold_buf_nxt;
      r_discard_addr <= w_discard_addr_nxt;
    end
  end

  always_comb begin
    w_state_nxt        = r_state;
    w_pc_nxt           = r_pc;
    w_hold_buf_nxt     = r_hold_buf;
    w_discard_addr_nxt = r_discard_addr;
    imem_req           = 1'b0;
    imem_addr          = r_pc;
    instr_IF           = NOP_INSTR;
    instr_valid_IF     = 1'b0;

    case (r_state)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          if (redirect) begin
            w_pc_nxt = w_redirect_pc;
          end else begin
            instr_IF       = imem_rdata;
            instr_valid_IF = 1'b1;
            if (stall) begin
              w_hold_buf_nxt = imem_rdata;
              w_state_nxt    = S_HOLD;
            end else begin
              w_pc_nxt = w_pc_plus4;
            end
          end
        end else if (redirect) begin
          // Request for r_pc is still in flight; remember it so the address stays put.
          w_discard_addr_nxt = r_pc;
          w_pc_nxt           = w_redirect_pc;
          w_state_nxt        = S_DISCARD;
        end
      end

      S_HOLD: begin
        if (redirect) begin
          w_pc_nxt    = w_redirect_pc;
          w_state_nxt = S_FETCH;
        end else begin
          instr_IF       = r_hold_buf;
          instr_valid_IF = 1'b1;
          if (!stall) begin
            w_pc_nxt    = w_pc_plus4;
            w_state_nxt = S_FETCH;
          end
        end
      end

      S_DISCARD: begin
        imem_req  = 1'b1;
        imem_addr = r_discard_addr;
        if (redirect) begin
          w_pc_nxt = w_redirect_pc;
        end
        if (imem_ready) begin
          w_state_nxt = S_FETCH;
        end
      end

      default: begin
        w_state_nxt = S_FETCH;
      end
    endcase

    // Reset abandons any outstanding request and suppresses delivery.
    if (rst) begin
      imem_req       = 1'b0;
      instr_IF       = NOP_INSTR;
      instr_valid_IF = 1'b0;
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed vector table for the multi-cycle corner
// cases, then randomized traffic checked against an in-order program model.
module tb_if_fetch_stage;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] KEY       = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] pcPlus4_IF;
  logic [31:0] instr_IF;
  logic        instr_valid_IF;

  int n_checks = 0;
  int n_fail   = 0;

  if_fetch_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rdata     (imem_rdata),
    .pcPlus4_IF     (pcPlus4_IF),
    .instr_IF       (instr_IF),
    .instr_valid_IF (instr_valid_IF)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic        rdy;
    logic        ereq;
    logic [31:0] eaddr;
    logic [31:0] einstr;
    logic        evld;
    logic [31:0] epc4;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic s, logic rd, logic [31:0] rpc, logic rdy,
                              logic ereq, logic [31:0] eaddr, logic [31:0] einstr,
                              logic evld, logic [31:0] epc4);
    vec_t v;
    v.rst = r; v.stall = s; v.redir = rd; v.rpc = rpc; v.rdy = rdy;
    v.ereq = ereq; v.eaddr = eaddr; v.einstr = einstr; v.evld = evld; v.epc4 = epc4;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory model: a completing request returns addr ^ KEY; otherwise garbage.
  task automatic drive(input logic r, input logic s, input logic rd,
                       input logic [31:0] rpc, input logic rdy);
    rst         = r;
    stall       = s;
    redirect    = rd;
    redirect_pc = rpc;
    imem_ready  = rdy;
    imem_rdata  = rdy ? (imem_addr ^ KEY) : $urandom;
  endtask

  initial begin
    logic [31:0] arch_pc;
    logic        prev_pend;
    logic [31:0] prev_addr;
    int          delivered;
    logic        r_rst, r_st, r_rd, r_rdy;
    logic [31:0] r_rpc;

    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
    imem_ready = 1'b0; imem_rdata = 32'd0;
    repeat (2) @(posedge clk);

    //              rst st rd rpc           rdy req addr          instr         vld pc+4
    tbl.push_back(mk(1, 0, 0, 32'h0,        1,  0,  32'h0,        NOP_INSTR,    0,  32'h4));
    tbl.push_back(mk(0, 0, 0, 32'h0,        1,  1,  32'h0,        32'hA5A5_0000, 1, 32'h4));
    tbl.push_back(mk(0, 0, 0, 32'h0,        1,  1,  32'h4,        32'hA5A5_0004, 1, 32'h8));
    tbl.push_back(mk(0, 1, 0, 32'h0,        1,  1,  32'h8,        32'hA5A5_0008, 1, 32'hC));
    tbl.push_back(mk(0, 1, 0, 32'h0,        1,  0,  32'h0,        32'hA5A5_0008, 1, 32'hC));
    tbl.push_back(mk(0, 1, 0, 32'h0,        1,  0,  32'h0,        32'hA5A5_0008, 1, 32'hC));
    tbl.push_back(mk(0, 0, 0, 32'h0,        1,  0,  32'h0,        32'hA5A5_0008, 1, 32'hC));
    tbl.push_back(mk(0, 0, 0, 32'h0,        1,  1,  32'hC,        32'hA5A5_000C, 1, 32'h10));
    tbl.push_back(mk(0, 0, 1, 32'h103,      0,  1,  32'h10,       NOP_INSTR,    0,  32'h14));
    tbl.push_back(mk(0, 0, 0, 32'h0,        0,  1,  32'h10,       NOP_INSTR,    0,  32'h104));
    tbl.push_back(mk(0, 0, 0, 32'h0,        1,  1,  32'h10,       NOP_INSTR,    0,  32'h104));
    tbl.push_back(mk(0, 1, 0, 32'h0,        1,  1,  32'h100,      32'hA5A5_0100, 1, 32'h104));
    tbl.push_back(mk(0, 1, 1, 32'h40,       1,  0,  32'h0,        NOP_INSTR,    0,  32'h104));
    tbl.push_back(mk(0, 0, 0, 32'h0,        1,  1,  32'h40,       32'hA5A5_0040, 1, 32'h44));
    tbl.push_back(mk(0, 0, 1, 32'hFFFF_FFFF,1,  1,  32'h44,       NOP_INSTR,    0,  32'h48));
    tbl.push_back(mk(0, 0, 0, 32'h0,        1,  1,  32'hFFFF_FFFC,32'h5A5A_FFFC, 1, 32'h0));
    tbl.push_back(mk(0, 0, 0, 32'h0,        1,  1,  32'h0,        32'hA5A5_0000, 1, 32'h4));
    tbl.push_back(mk(0, 0, 1, 32'h200,      0,  1,  32'h4,        NOP_INSTR,    0,  32'h8));
    tbl.push_back(mk(1, 0, 0, 32'h0,        0,  0,  32'h0,        NOP_INSTR,    0,  32'h204));
    tbl.push_back(mk(0, 0, 0, 32'h0,        0,  1,  RESET_PC,     NOP_INSTR,    0,  32'h4));
    tbl.push_back(mk(0, 0, 0, 32'h0,        1,  1,  RESET_PC,     32'hA5A5_0000, 1, 32'h4));
    tbl.push_back(mk(0, 1, 0, 32'h0,        0,  1,  32'h4,        NOP_INSTR,    0,  32'h8));
    tbl.push_back(mk(0, 0, 0, 32'h0,        1,  1,  32'h4,        32'hA5A5_0004, 1, 32'h8));
    tbl.push_back(mk(0, 0, 1, 32'h300,      0,  1,  32'h8,        NOP_INSTR,    0,  32'hC));
    tbl.push_back(mk(0, 0, 1, 32'h500,      1,  1,  32'h8,        NOP_INSTR,    0,  32'h304));
    tbl.push_back(mk(0, 0, 0, 32'h0,        1,  1,  32'h500,      32'hA5A5_0500, 1, 32'h504));

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].rst, tbl[i].stall, tbl[i].redir, tbl[i].rpc, tbl[i].rdy);
      #1;
      chk($sformatf("vec%0d.req", i),   {31'd0, imem_req},       {31'd0, tbl[i].ereq});
      if (tbl[i].ereq)
        chk($sformatf("vec%0d.addr", i), imem_addr,              tbl[i].eaddr);
      chk($sformatf("vec%0d.instr", i), instr_IF,                tbl[i].einstr);
      chk($sformatf("vec%0d.valid", i), {31'd0, instr_valid_IF}, {31'd0, tbl[i].evld});
      chk($sformatf("vec%0d.pc4", i),   pcPlus4_IF,              tbl[i].epc4);
    end

    // Random phase: the model only knows the next program-order PC.
    @(negedge clk);
    drive(1, 0, 0, 32'd0, 0);
    @(negedge clk);
    arch_pc   = RESET_PC;
    prev_pend = 1'b0;
    prev_addr = 32'd0;
    delivered = 0;
    for (int c = 0; c < 4000; c++) begin
      r_rst = ($urandom_range(0, 299) == 0);
      r_st  = ($urandom_range(0, 2) == 0);
      r_rd  = ($urandom_range(0, 9) == 0);
      r_rdy = ($urandom_range(0, 1) == 1);
      case ($urandom_range(0, 2))
        0:       r_rpc = $urandom;
        1:       r_rpc = 32'hFFFF_FFF0 + $urandom_range(0, 15);
        default: r_rpc = $urandom_range(0, 255);
      endcase
      drive(r_rst, r_st, r_rd, r_rpc, r_rdy);
      #1;
      if (r_rst) begin
        chk("rnd.rst_req",   {31'd0, imem_req},       32'd0);
        chk("rnd.rst_valid", {31'd0, instr_valid_IF}, 32'd0);
      end else begin
        if (prev_pend) begin
          chk("rnd.req_held",  {31'd0, imem_req}, 32'd1);
          chk("rnd.addr_held", imem_addr,         prev_addr);
        end
        if (r_rd)
          chk("rnd.redir_valid", {31'd0, instr_valid_IF}, 32'd0);
        if (instr_valid_IF) begin
          chk("rnd.instr", instr_IF,   arch_pc ^ KEY);
          chk("rnd.pc4",   pcPlus4_IF, arch_pc + 32'd4);
        end else begin
          chk("rnd.nop", instr_IF, NOP_INSTR);
        end
      end
      if (r_rst)
        arch_pc = RESET_PC;
      else if (r_rd)
        arch_pc = r_rpc & ~32'd3;
      else if (instr_valid_IF && !r_st) begin
        arch_pc = arch_pc + 32'd4;
        delivered++;
      end
      prev_pend = imem_req && !r_rdy && !r_rst;
      prev_addr = imem_addr;
      @(negedge clk);
    end
    chk("rnd.progress", {31'd0, delivered >= 300}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
